// File: rtl/sa_ram_pkg.sv
// Shared definitions for the single-port-style RAM: zero-fill FSM encoding
// and the constant helpers used to size address and mask ports.
package sa_ram_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sa_ram_core.sv
// Storage array with a lane-masked write port and an asynchronous read port;
// the read port is sampled by the output register in the top.
module sa_ram_core
  import sa_ram_pkg::*;
#(
  parameter int DEPTH     = 80,
  parameter int WIDTH     = 514,
  parameter int MASK_GRAN = 514,
  parameter int AW        = 7,
  parameter int MW        = 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [MW-1:0]    wmask,
  input  logic [WIDTH-1:0] di,
  input  logic [AW-1:0]    ra,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] bit_mask_s;

  // The last lane may be narrower than MASK_GRAN; each bit simply follows its lane.
  for (genvar b = 0; b < WIDTH; b++) begin : g_lane_bits
    assign bit_mask_s[b] = wmask[b / MASK_GRAN];
  end

  // Lane-masked word write; unmasked bits keep their stored value.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wa] <= (mem_r[wa] & ~bit_mask_s) | (di & bit_mask_s);
    end
  end

  assign rdata = mem_r[ra];

endmodule

// File: rtl/sa_ram_rwsp_param.sv
// Registered-read RAM with lane-masked writes, address validation, sticky
// range error and an optional zero-fill sequence after reset.
module sa_ram_rwsp_param
  import sa_ram_pkg::*;
#(
  parameter int DEPTH          = 80,
  parameter int WIDTH          = 514,
  parameter int MASK_GRAN      = 514,
  parameter bit CLEAR_ON_RESET = 1'b1,
  localparam int AW = max_int(1, clog2(DEPTH)),
  localparam int MW = ceil_div(WIDTH, MASK_GRAN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    ra,
  input  logic             re,
  input  logic             ore,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic [AW-1:0]    wa,
  input  logic             we,
  input  logic [MW-1:0]    wmask,
  input  logic [WIDTH-1:0] di,
  output logic             init_busy,
  output logic             addr_err,
  input  logic [31:0]      pwrbus_ram_pd
);

  localparam logic [AW:0]   DEPTH_X   = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_e           state_r, state_nx;
  logic [AW-1:0]    counter_r, counter_nx;
  logic [AW-1:0]    ra_d_r;
  logic             s1_vld_r;
  logic             busy_s;
  logic             wa_ok_s, ra_ok_s;
  logic             mem_we_s;
  logic [AW-1:0]    mem_wa_s;
  logic [MW-1:0]    mem_mask_s;
  logic [WIDTH-1:0] mem_di_s;
  logic [WIDTH-1:0] rdata_s;
  logic             unused_pwr_s;

  assign unused_pwr_s = ^pwrbus_ram_pd;
  assign busy_s       = (state_r == ST_CLEAR);
  assign init_busy    = busy_s;
  assign wa_ok_s      = ({1'b0, wa} < DEPTH_X);
  assign ra_ok_s      = ({1'b0, ra} < DEPTH_X);

  // Zero-fill state and address counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      counter_r <= {AW{1'b0}};
    end else begin
      state_r   <= state_nx;
      counter_r <= counter_nx;
    end
  end

  // Zero-fill next state: walk every address once, then go idle.
  always_comb begin
    state_nx   = state_r;
    counter_nx = counter_r;
    case (state_r)
      ST_IDLE: begin
        state_nx   = ST_IDLE;
        counter_nx = counter_r;
      end
      ST_CLEAR: begin
        if (counter_r == LAST_ADDR) begin
          state_nx   = ST_IDLE;
          counter_nx = {AW{1'b0}};
        end else begin
          state_nx   = ST_CLEAR;
          counter_nx = counter_r + {{(AW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nx   = ST_IDLE;
        counter_nx = {AW{1'b0}};
      end
    endcase
  end

  // Array write port: fill owns it while busy, user writes need a valid address.
  always_comb begin
    mem_we_s   = 1'b0;
    mem_wa_s   = wa;
    mem_mask_s = wmask;
    mem_di_s   = di;
    if (reset) begin
      mem_we_s = 1'b0;
    end else if (busy_s) begin
      mem_we_s   = 1'b1;
      mem_wa_s   = counter_r;
      mem_mask_s = {MW{1'b1}};
      mem_di_s   = {WIDTH{1'b0}};
    end else if (we && wa_ok_s && (wmask != {MW{1'b0}})) begin
      mem_we_s = 1'b1;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  sa_ram_core #(
    .DEPTH     (DEPTH),
    .WIDTH     (WIDTH),
    .MASK_GRAN (MASK_GRAN),
    .AW        (AW),
    .MW        (MW)
  ) u_core (
    .clk   (clk),
    .we    (mem_we_s),
    .wa    (mem_wa_s),
    .wmask (mem_mask_s),
    .di    (mem_di_s),
    .ra    (ra_d_r),
    .rdata (rdata_s)
  );

  // Read pipeline: address capture, output register and sticky range error.
  always_ff @(posedge clk) begin
    if (reset) begin
      ra_d_r   <= {AW{1'b0}};
      s1_vld_r <= 1'b0;
      dout     <= {WIDTH{1'b0}};
      dout_vld <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      if (re) begin
        if (ra_ok_s && !busy_s) begin
          ra_d_r   <= ra;
          s1_vld_r <= 1'b1;
        end else begin
          s1_vld_r <= 1'b0;
        end
      end
      // rdata_s reflects the array before this edge's write, giving old-data-on-collision.
      if (ore) begin
        dout     <= rdata_s;
        dout_vld <= s1_vld_r;
      end
      if (!busy_s && ((we && !wa_ok_s) || (re && !ra_ok_s))) begin
        addr_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/sa_ram_rwsp_param.md
SA_RAM_RWSP_PARAM -- requirements
Module: sa_ram_rwsp_param

Interface
REQ-001 SHALL expose the following parameters, one per line: name, default, meaning.
- DEPTH, 80, number of words.
- WIDTH, 514, bits per word.
- MASK_GRAN, 514, bits per write-mask lane.
- CLEAR_ON_RESET, 1, enables zero-fill of the array after reset.
REQ-002 SHALL derive localparams AW = max(1, clog2(DEPTH)) and MW = ceil(WIDTH/MASK_GRAN); the last lane MAY be partial.
REQ-003 SHALL have one clock and a synchronous, active-high reset, with ports (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- reset, in, 1, synchronous active-high reset.
- ra, in, AW, read address.
- re, in, 1, read-address capture enable.
- ore, in, 1, output-register capture enable.
- dout, out, WIDTH, registered read data.
- dout_vld, out, 1, dout holds data from an accepted read.
- wa, in, AW, write address.
- we, in, 1, write enable.
- wmask, in, MW, per-lane write enable.
- di, in, WIDTH, write data.
- init_busy, out, 1, zero-fill in progress.
- addr_err, out, 1, sticky out-of-range flag.
- pwrbus_ram_pd, in, 32, power control; functionally ignored.

Function
REQ-004 SHALL write, at the clk edge where we=1, wa<DEPTH and init_busy=0, lane i of di into M[wa] for each wmask[i]=1; lanes with wmask[i]=0 SHALL keep their value.
REQ-005 SHALL accept a read address at the edge where re=1, ra<DEPTH and init_busy=0: ra_d<=ra, s1_vld<=1.
REQ-006 SHALL leave ra_d and s1_vld unchanged when re=0.
REQ-007 SHALL clear s1_vld and leave ra_d unchanged at an edge where re=1 but the read is rejected (out of range or busy).
REQ-008 SHALL, at an edge with ore=1, load dout<=M[ra_d] (array contents before that edge's write) and dout_vld<=s1_vld; with ore=0 both SHALL hold.
REQ-009 SHALL give a minimum read latency of 2 edges: re at edge N, ore at edge N+1, dout valid after N+1.
REQ-010 SHALL return old data when a write to ra_d and ore occur at the same edge; the new data SHALL be visible at the next ore.
REQ-011 SHALL let independent re and ore proceed in the same cycle: dout takes the previous ra_d while ra_d updates.
REQ-012 SHALL drop any we with wa>=DEPTH or any re with ra>=DEPTH, and in either case set addr_err at that edge; addr_err SHALL stay set until reset. Requests arriving while init_busy=1 SHALL NOT set addr_err.
REQ-013 SHALL, when we=1 and wmask=0, perform no write and no error.
REQ-014 SHALL implement the zero-fill state machine IDLE/CLEAR when CLEAR_ON_RESET=1:
- Reset forces CLEAR with counter=0.
- Each edge in CLEAR with reset=0 writes all-zero to M[counter] and increments the counter.
- After the edge writing DEPTH-1, the machine goes to IDLE.
- init_busy=1 exactly while in CLEAR, i.e. for DEPTH cycles after reset deasserts.
REQ-015 SHALL, when CLEAR_ON_RESET=0, hold init_busy=0 with array contents undefined after reset.
REQ-016 SHALL ignore user re/we entirely during CLEAR; ore SHALL still operate.

Reset
REQ-017 SHALL, while reset=1, force ra_d=0, s1_vld=0, dout=0, dout_vld=0, addr_err=0, counter=0; init_busy=CLEAR_ON_RESET.
REQ-018 SHALL restart the zero-fill from address 0 when reset is asserted mid-CLEAR.
REQ-019 SHALL NOT write the array from user ports during reset.

Structure
REQ-020 SHALL place the FSM state encoding (IDLE, CLEAR) and the clog2/ceil-div helper functions in the shared package sa_ram_pkg.
REQ-021 SHALL implement the storage array with per-lane write in one sub-module, sa_ram_core; the FSM, validation, and output register SHALL reside in the top.

Verification
REQ-022 SHALL cover a clear check: reset 1 cycle with DEPTH=80 -> init_busy high 80 cycles; then reading address 79 gives dout=0, dout_vld=1.
REQ-023 SHALL cover masked write: MASK_GRAN=8, WIDTH=32; write 0xFFFFFFFF, then di=0x12345678 with wmask=0b0101 -> read returns 0xFF34FF78.
REQ-024 SHALL cover a write/read collision: M[5]=0xA; re ra=5 at N; at N+1 we wa=5 di=0xB plus ore -> dout=0xA; ore at N+2 -> dout=0xB.
REQ-025 SHALL cover out-of-range access: DEPTH=80; we wa=100 -> no write, addr_err=1; re ra=90 -> ra_d unchanged, next ore gives dout_vld=0; addr_err persists until reset.
REQ-026 SHALL cover reset mid-clear: reset at clear cycle 40 -> init_busy remains high 80 full cycles after release, and all words read 0.
REQ-027 SHALL cover busy blocking: we wa=3 di=0x7 during CLEAR -> M[3]=0 afterwards, addr_err=0.
